// File: rtl/traffic_signal_controller.sv
// Highway/country junction light controller: five-state Moore FSM with timed yellow/all-red dwells.
// Latency: lamps decode straight from the state register, so they change just after the edge that moves the state.
// Backpressure: none; the sensor input is sampled every cycle and the lamp outputs are never stalled.
module traffic_signal_controller #(
    parameter int Y2RDELAY = 1,
    parameter int R2GDELAY = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       x,
    output logic [1:0] Hwy,
    output logic [1:0] Cnrty
);

    localparam logic [1:0] RED    = 2'b00;
    localparam logic [1:0] YELLOW = 2'b01;
    localparam logic [1:0] GREEN  = 2'b10;

    // The exit is taken on the edge where the count reaches delay-1.
    localparam logic [7:0] Y2R_LAST = 8'(Y2RDELAY - 1);
    localparam logic [7:0] R2G_LAST = 8'(R2GDELAY - 1);

    typedef enum logic [2:0] {
        S0 = 3'd0,
        S1 = 3'd1,
        S2 = 3'd2,
        S3 = 3'd3,
        S4 = 3'd4
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [7:0] cnt;
    logic [7:0] cnt_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // cnt_nxt defaults to zero so every state change clears the dwell count.
    always_comb begin
        state_nxt = S0;
        cnt_nxt   = '0;
        Hwy       = RED;
        Cnrty     = RED;
        case (state)
            S0: begin
                Hwy       = GREEN;
                state_nxt = x ? S1 : S0;
            end
            S1: begin
                Hwy = YELLOW;
                if (cnt == Y2R_LAST) begin
                    state_nxt = S2;
                end else begin
                    state_nxt = S1;
                    cnt_nxt   = cnt + 8'd1;
                end
            end
            S2: begin
                if (cnt == R2G_LAST) begin
                    state_nxt = S3;
                end else begin
                    state_nxt = S2;
                    cnt_nxt   = cnt + 8'd1;
                end
            end
            S3: begin
                Cnrty     = GREEN;
                state_nxt = x ? S3 : S4;
            end
            S4: begin
                Cnrty = YELLOW;
                if (cnt == Y2R_LAST) begin
                    state_nxt = S0;
                end else begin
                    state_nxt = S4;
                    cnt_nxt   = cnt + 8'd1;
                end
            end
            // Illegal encodings show RED/RED and fall back to S0.
            default: begin
                state_nxt = S0;
            end
        endcase
    end

endmodule

// File: tb/tb_traffic_signal_controller.sv
// Directed bench: default-delay controller plus a Y2RDELAY=3 / R2GDELAY=2 instance.
module tb_traffic_signal_controller;

    logic       clk;
    logic       reset;
    logic       x;
    logic       x2;
    logic [1:0] hwy;
    logic [1:0] cnrty;
    logic [1:0] hwy2;
    logic [1:0] cnrty2;

    int n_checks;
    int n_fail;

    traffic_signal_controller dut (
        .clk   (clk),
        .reset (reset),
        .x     (x),
        .Hwy   (hwy),
        .Cnrty (cnrty)
    );

    traffic_signal_controller #(
        .Y2RDELAY (3),
        .R2GDELAY (2)
    ) dut2 (
        .clk   (clk),
        .reset (reset),
        .x     (x2),
        .Hwy   (hwy2),
        .Cnrty (cnrty2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        x  = 1'b0;
        x2 = 1'b0;
        reset = 1'b1;
        #1;
        n_checks++;
        if ({hwy, cnrty} !== 4'b1000) begin
            n_fail++;
            $display("FAIL reset_async_level got %b/%b want 10/00", hwy, cnrty);
        end
        x = 1'b1;
        step();
        n_checks++;
        if ({hwy, cnrty} !== 4'b1000) begin
            n_fail++;
            $display("FAIL reset_holds_on_edge got %b/%b want 10/00", hwy, cnrty);
        end
        x = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if ({hwy, cnrty} !== 4'b1000 || {hwy2, cnrty2} !== 4'b1000) begin
                n_fail++;
                $display("FAIL idle_s0 edge %0d got %b/%b %b/%b want 10/00", i, hwy, cnrty, hwy2, cnrty2);
            end
        end
    endtask

    task automatic test_sequence();
        logic [3:0] exp_tbl [5];
        exp_tbl[0] = 4'b0100;
        exp_tbl[1] = 4'b0000;
        exp_tbl[2] = 4'b0010;
        exp_tbl[3] = 4'b0001;
        exp_tbl[4] = 4'b1000;
        x = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            x = 1'b0;
            n_checks++;
            if ({hwy, cnrty} !== exp_tbl[i]) begin
                n_fail++;
                $display("FAIL sequence edge %0d got %b want %b", i, {hwy, cnrty}, exp_tbl[i]);
            end
        end
    endtask

    task automatic test_hold_s3();
        x = 1'b1;
        step();
        step();
        step();
        n_checks++;
        if ({hwy, cnrty} !== 4'b0010) begin
            n_fail++;
            $display("FAIL hold_enter_s3 got %b/%b want 00/10", hwy, cnrty);
        end
        for (int i = 0; i < 5; i++) begin
            step();
            n_checks++;
            if ({hwy, cnrty} !== 4'b0010) begin
                n_fail++;
                $display("FAIL hold_s3 edge %0d got %b/%b want 00/10", i, hwy, cnrty);
            end
        end
        x = 1'b0;
        step();
        n_checks++;
        if ({hwy, cnrty} !== 4'b0001) begin
            n_fail++;
            $display("FAIL hold_release_s4 got %b/%b want 00/01", hwy, cnrty);
        end
        step();
        n_checks++;
        if ({hwy, cnrty} !== 4'b1000) begin
            n_fail++;
            $display("FAIL hold_return_s0 got %b/%b want 10/00", hwy, cnrty);
        end
    endtask

    task automatic test_x_ignored();
        logic [3:0] exp_tbl [4];
        exp_tbl[0] = 4'b0000;
        exp_tbl[1] = 4'b0010;
        exp_tbl[2] = 4'b0001;
        exp_tbl[3] = 4'b1000;
        for (int pass = 0; pass < 3; pass++) begin
            x = 1'b1;
            step();
            n_checks++;
            if ({hwy, cnrty} !== 4'b0100) begin
                n_fail++;
                $display("FAIL xign_s1 pass %0d got %b/%b want 01/00", pass, hwy, cnrty);
            end
            for (int i = 0; i < 4; i++) begin
                // S3 is the only state here where x steers; force it low there.
                x = (i == 2) ? 1'b0 : 1'($urandom_range(0, 1));
                if (i == 3) x = 1'b0;
                if (i == 1) x = 1'($urandom_range(0, 1));
                step();
                n_checks++;
                if ({hwy, cnrty} !== exp_tbl[i]) begin
                    n_fail++;
                    $display("FAIL xign pass %0d edge %0d got %b want %b", pass, i, {hwy, cnrty}, exp_tbl[i]);
                end
                n_checks++;
                if (hwy !== 2'b00 && cnrty !== 2'b00) begin
                    n_fail++;
                    $display("FAIL safety pass %0d edge %0d got %b/%b want one side 00", pass, i, hwy, cnrty);
                end
            end
        end
    endtask

    task automatic test_delays();
        logic [3:0] exp_tbl [10];
        exp_tbl[0] = 4'b0100;
        exp_tbl[1] = 4'b0100;
        exp_tbl[2] = 4'b0100;
        exp_tbl[3] = 4'b0000;
        exp_tbl[4] = 4'b0000;
        exp_tbl[5] = 4'b0010;
        exp_tbl[6] = 4'b0001;
        exp_tbl[7] = 4'b0001;
        exp_tbl[8] = 4'b0001;
        exp_tbl[9] = 4'b1000;
        x  = 1'b0;
        x2 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            x2 = 1'b0;
            n_checks++;
            if ({hwy2, cnrty2} !== exp_tbl[i]) begin
                n_fail++;
                $display("FAIL delays edge %0d got %b want %b", i, {hwy2, cnrty2}, exp_tbl[i]);
            end
        end
        n_checks++;
        if ({hwy, cnrty} !== 4'b1000) begin
            n_fail++;
            $display("FAIL delays_default_idle got %b/%b want 10/00", hwy, cnrty);
        end
    endtask

    task automatic test_async_reset();
        // Default instance into S3, slow instance mid-dwell in S1.
        x  = 1'b1;
        x2 = 1'b1;
        step();
        x  = 1'b0;
        x2 = 1'b0;
        step();
        step();
        n_checks++;
        if ({hwy, cnrty} !== 4'b0010 || {hwy2, cnrty2} !== 4'b0100) begin
            n_fail++;
            $display("FAIL areset_setup got %b/%b %b/%b want 00/10 01/00", hwy, cnrty, hwy2, cnrty2);
        end
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if ({hwy, cnrty} !== 4'b1000) begin
            n_fail++;
            $display("FAIL areset_from_s3 got %b/%b want 10/00", hwy, cnrty);
        end
        n_checks++;
        if ({hwy2, cnrty2} !== 4'b1000) begin
            n_fail++;
            $display("FAIL areset_from_s1_dwell got %b/%b want 10/00", hwy2, cnrty2);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            n_checks++;
            if ({hwy, cnrty} !== 4'b1000 || {hwy2, cnrty2} !== 4'b1000) begin
                n_fail++;
                $display("FAIL areset_stay_s0 edge %0d got %b/%b %b/%b want 10/00", i, hwy, cnrty, hwy2, cnrty2);
            end
        end
        // A fresh S1 dwell on the slow instance must again last three cycles.
        x2 = 1'b1;
        step();
        x2 = 1'b0;
        step();
        step();
        n_checks++;
        if ({hwy2, cnrty2} !== 4'b0100) begin
            n_fail++;
            $display("FAIL areset_fresh_dwell got %b/%b want 01/00", hwy2, cnrty2);
        end
        step();
        n_checks++;
        if ({hwy2, cnrty2} !== 4'b0000) begin
            n_fail++;
            $display("FAIL areset_fresh_dwell_exit got %b/%b want 00/00", hwy2, cnrty2);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_sequence();
        test_hold_s3();
        test_x_ignored();
        test_delays();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
